frequency_counter_scheduler: RTL
================================

# frequency_counter_scheduler

Time-multiplexes one `frequency_counter` instance across up to `NUMBER_OF_CHANNELS` unknown clocks. Drives the select line of the external clock mux and discards stale measurement windows after each switch. Stores one 32-bit result per channel in a readable register bank, with per-channel fresh and timeout flags. Runs entirely in the reference clock domain, alongside the counter's `reference_clock`.

## Interface
- `NUMBER_OF_CHANNELS`, 4: number of unknown clocks behind the mux; range 2..16.
- `LOG2_OF_NUMBER_OF_CHANNELS`, `$clog2(NUMBER_OF_CHANNELS)`: width of the select and read address.
- `DISCARD_COUNT`, 2: `counter_valid` pulses ignored after each switch; range 0..15.
- `TIMEOUT_CYCLES`, 2**28: reference cycles allowed per channel before giving up.
- `reference_clock`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = run sweeps continuously; 0 = return to IDLE.
- `channel_mask`  in  N  channels to include in a sweep; sampled at sweep start.
- `counter_frequency`  in  32  result from `frequency_counter`.
- `counter_valid`  in  1  one-cycle pulse from `frequency_counter`.
- `select`  out  LOG2  mux select for the unknown clock.
- `read_channel`  in  LOG2  read address.
- `read_strobe`  in  1  clears the fresh flag of `read_channel`.
- `read_frequency`  out  32  registered value of `results[read_channel]`.
- `fresh`  out  N  per-channel flag: new result since last read.
- `timed_out`  out  N  per-channel flag: last attempt on this channel timed out.
- `busy`  out  1  high whenever state ≠ IDLE.
- `sweep_done`  out  1  one-cycle pulse after the last masked channel is stored.

## Operation
- States: IDLE, SWITCH, DISCARD, MEASURE, STORE.
- IDLE → SWITCH when `enable`=1 and `channel_mask`≠0.
  - On this transition: latch the mask; set `select` to the lowest set bit.
- SWITCH lasts exactly 1 cycle and clears the discard counter and the timeout counter.
  - Goes to DISCARD, or directly to MEASURE if `DISCARD_COUNT`=0.
- DISCARD counts `counter_valid` pulses. The pulse that reaches `DISCARD_COUNT` moves the block to MEASURE.
- MEASURE: on `counter_valid`, go to STORE.
  - `results[select]` ← `counter_frequency`.
  - `fresh[select]` ← 1; `timed_out[select]` ← 0.
- STORE: advance `select` to the next higher set bit of the latched mask.
  - If one exists: → SWITCH.
  - If none: pulse `sweep_done` and wrap to the lowest set bit. Then → SWITCH if `enable`=1 and the newly sampled mask is ≠0; otherwise → IDLE.
- Timeout (see Configuration): the counter runs in DISCARD and MEASURE. On reaching `TIMEOUT_CYCLES`:
  - `results[select]` ← 0; `timed_out[select]` ← 1; `fresh[select]` ← 1.
  - → STORE.
- `enable`=0 in any state → IDLE on the next edge.
  - Results and flags are retained.
  - `select` holds its value.
- `counter_valid` in IDLE, SWITCH or STORE is ignored.
- A `read_strobe` that coincides with a store to the same channel leaves `fresh` at 1; the store wins.
- Reset values:
  - `select`=0, `read_frequency`=0, `fresh`=0, `timed_out`=0.
  - `busy`=0, `sweep_done`=0, all results=0, state=IDLE.

## Timing
- `select` changes only on the edge that enters SWITCH.
- Store latency: `counter_valid` high in MEASURE at edge k → result, `fresh` and state STORE updated at edge k+1. `read_frequency` reflects the new value at edge k+2 when addressed.
- `read_frequency` latency: 1 cycle from `read_channel`.
- `sweep_done` is high for exactly the STORE cycle of the last channel.
- Per-channel dwell ≈ (`DISCARD_COUNT`+1) counter windows, plus 2 cycles.
- Single-channel mask: cycles SWITCH→…→STORE→SWITCH on the same `select`, with `sweep_done` pulsing every measurement.

## Configuration
- `FREQUENCY_COUNTER_SCHEDULER_TIMEOUT_EN` defined:
  - The timeout counter is built at width `$clog2(TIMEOUT_CYCLES+1)`.
  - Behaviour is as described under Operation.
- Not defined:
  - No timeout counter is built.
  - DISCARD and MEASURE wait indefinitely.
  - `timed_out` is tied to 0.

## Test plan
- N=4, mask=4'b1011, `DISCARD_COUNT`=2, counter model emits values 100×(channel+1) every 64 cycles → `select` sequence 0,1,3,0…; `results` = 100, 200, —, 400; `sweep_done` pulses once per sweep; `fresh`=4'b1011.
- 3 valids after a switch with `DISCARD_COUNT`=2 → only the 3rd is stored; the first two leave `results` unchanged.
- TIMEOUT_EN defined, `TIMEOUT_CYCLES`=200, channel 1 never produces valid → after 200 cycles in DISCARD/MEASURE: `results[1]`=0, `timed_out[1]`=1, sweep continues with channel 3.
- `read_strobe` on channel 0 in the same cycle that channel 0 is stored → `fresh[0]` stays 1. A later strobe alone → `fresh[0]`=0 next edge.
- `enable` dropped mid-MEASURE → IDLE next edge; `busy`=0; results retained. Mask=0 with `enable`=1 → stays IDLE.
- `reset_n` asserted mid-DISCARD, with no clock edge → all outputs immediately at reset values.

Source files
------------

// File: rtl/frequency_counter_scheduler.sv
// frequency_counter_scheduler: shares one frequency counter across N muxed clocks.
// Define FREQUENCY_COUNTER_SCHEDULER_TIMEOUT_EN to build the per-channel timeout.
module frequency_counter_scheduler #(
  parameter int NUMBER_OF_CHANNELS         = 4,
  parameter int LOG2_OF_NUMBER_OF_CHANNELS = $clog2(NUMBER_OF_CHANNELS),
  parameter int DISCARD_COUNT              = 2,
  parameter int TIMEOUT_CYCLES             = 2**28
) (
  input  logic                                  reference_clock,
  input  logic                                  reset_n,
  input  logic                                  enable,
  input  logic [NUMBER_OF_CHANNELS-1:0]         channel_mask,
  input  logic [31:0]                           counter_frequency,
  input  logic                                  counter_valid,
  output logic [LOG2_OF_NUMBER_OF_CHANNELS-1:0] select,
  input  logic [LOG2_OF_NUMBER_OF_CHANNELS-1:0] read_channel,
  input  logic                                  read_strobe,
  output logic [31:0]                           read_frequency,
  output logic [NUMBER_OF_CHANNELS-1:0]         fresh,
  output logic [NUMBER_OF_CHANNELS-1:0]         timed_out,
  output logic                                  busy,
  output logic                                  sweep_done
);
  localparam int N  = NUMBER_OF_CHANNELS;
  localparam int LW = LOG2_OF_NUMBER_OF_CHANNELS;

  typedef enum logic [2:0] {
    IDLE, SWITCH, DISCARD, MEASURE, STORE
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [N-1:0]  fresh_q, fresh_d;
  logic [N-1:0]  to_q, to_d;
  logic [LW-1:0] sel_q, sel_d;
  logic [3:0]    disc_q, disc_d;
  logic [31:0]   res_q [N];
  logic [31:0]   res_d [N];
  logic [31:0]   rd_q, rd_d;
  logic          done_q, done_d;
  logic          st_en, st_to;
  logic [31:0]   st_val;
  logic          tmo_hit;
  logic          rd_ok;

  function automatic logic [LW-1:0] lowest(input logic [N-1:0] m);
    lowest = '0;
    for (int i = N - 1; i >= 0; i--)
      if (m[i]) lowest = LW'(i);
  endfunction

  function automatic logic has_above(input logic [N-1:0] m,
                                     input logic [LW-1:0] c);
    has_above = 1'b0;
    for (int i = 0; i < N; i++)
      if (m[i] && i > int'(c)) has_above = 1'b1;
  endfunction

  function automatic logic [LW-1:0] next_above(input logic [N-1:0] m,
                                               input logic [LW-1:0] c);
    next_above = c;
    for (int i = N - 1; i >= 0; i--)
      if (m[i] && i > int'(c)) next_above = LW'(i);
  endfunction

`ifdef FREQUENCY_COUNTER_SCHEDULER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          waiting;

  assign waiting = (state_q == DISCARD) || (state_q == MEASURE);
  assign tmo_hit = waiting && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == SWITCH) tmo_d = '0;
    else if (waiting)      tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge reference_clock or negedge reset_n) begin
    if (!reset_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  // No timeout hardware: the wait states never give up.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  assign rd_ok = int'(read_channel) < N;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    disc_d  = disc_q;
    fresh_d = fresh_q;
    to_d    = to_q;
    res_d   = res_q;
    done_d  = 1'b0;
    st_en   = 1'b0;
    st_to   = 1'b0;
    st_val  = '0;
    rd_d    = rd_ok ? res_q[read_channel] : '0;
    if (read_strobe && rd_ok) fresh_d[read_channel] = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (|channel_mask) begin
          mask_d  = channel_mask;
          sel_d   = lowest(channel_mask);
          state_d = SWITCH;
        end
        SWITCH: begin
          disc_d  = '0;
          state_d = (DISCARD_COUNT == 0) ? MEASURE : DISCARD;
        end
        DISCARD: begin
          if (tmo_hit) begin
            st_en = 1'b1;
            st_to = 1'b1;
          end else if (counter_valid) begin
            if (int'(disc_q) + 1 >= DISCARD_COUNT) state_d = MEASURE;
            else disc_d = disc_q + 4'd1;
          end
        end
        MEASURE: begin
          if (counter_valid) begin
            st_en  = 1'b1;
            st_val = counter_frequency;
          end else if (tmo_hit) begin
            st_en = 1'b1;
            st_to = 1'b1;
          end
        end
        STORE: begin
          if (has_above(mask_q, sel_q)) begin
            sel_d   = next_above(mask_q, sel_q);
            state_d = SWITCH;
          end else if (|channel_mask) begin
            mask_d  = channel_mask;
            sel_d   = lowest(channel_mask);
            state_d = SWITCH;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // A store overrides a same-cycle read strobe on that channel.
    if (st_en) begin
      res_d[sel_q]   = st_val;
      fresh_d[sel_q] = 1'b1;
      to_d[sel_q]    = st_to;
      state_d        = STORE;
      done_d         = !has_above(mask_q, sel_q);
    end
  end

  always_ff @(posedge reference_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      sel_q   <= '0;
      disc_q  <= '0;
      fresh_q <= '0;
      to_q    <= '0;
      res_q   <= '{default: '0};
      rd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      disc_q  <= disc_d;
      fresh_q <= fresh_d;
      to_q    <= to_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  assign select         = sel_q;
  assign read_frequency = rd_q;
  assign fresh          = fresh_q;
  assign timed_out      = to_q;
  assign busy           = (state_q != IDLE);
  assign sweep_done     = done_q;
endmodule
